// File: rtl/pipe_pkg.sv
// Shared definitions for the credit-based pipeline receive block: default word
// width, control FSM states and the occupancy-count width helper.
package pipe_pkg;

  localparam int PIPE_WIDTH = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pipe_state_t;

  // Occupancy must reach DEPTH itself, hence one bit more than the pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipe_credit_rx_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port; storage is not reset.
module pipe_credit_rx_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_credit_rx.sv
// Receive end of a non-stallable pipeline: buffers words in a FWFT FIFO, returns
// one credit per consumed word after an initial DEPTH-credit grant. Optional
// parity checking is enabled with PIPE_CREDIT_RX_PARITY_EN.
module pipe_credit_rx
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             credit_ret,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow
`ifdef PIPE_CREDIT_RX_PARITY_EN
  ,
  input  logic             in_par,
  output logic             par_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  pipe_state_t      state, state_nxt;
  logic [AW-1:0]    init_cnt, init_cnt_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data, last_q;
  logic             credit_nxt;
  logic             full, pop, push, drop;

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  pipe_credit_rx_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // When empty, present the last word taken rather than stale array contents.
  assign out_data = out_valid ? rd_data : last_q;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    credit_nxt   = pop;
    case (state)
      INIT: begin
        credit_nxt   = 1'b1;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        credit_nxt = pop;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      init_cnt   <= '0;
      credit_ret <= 1'b0;
    end else begin
      state      <= state_nxt;
      init_cnt   <= init_cnt_nxt;
      credit_ret <= credit_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= rd_data;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef PIPE_CREDIT_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             par_err <= 1'b0;
    else if (push && (in_par != ^in_data))  par_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Scoreboard bench: a queue-based reference model predicts per-cycle status and
// the word stream; a negedge monitor compares the DUT against it.
module tb_pipe_credit_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             credit_ret;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             in_par = 1'b0;
  logic             par_err;
  bit               par_flip = 1'b0;

  pipe_credit_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .credit_ret (credit_ret),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .overflow   (overflow)
`ifdef PIPE_CREDIT_RX_PARITY_EN
    ,
    .in_par     (in_par),
    .par_err    (par_err)
`endif
  );

`ifndef PIPE_CREDIT_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ovf;
    bit cred;
    bit vld;
    int hold;
    bit par;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   mq[$];
  int   exp_q[$];
  exp_t cyc_q[$];
  int   last_m, init_left;
  bit   ovf_m, cred_m, par_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete(); cyc_q.delete();
    last_m = 0; ovf_m = 0; cred_m = 0; par_m = 0;
    init_left = DEPTH;
  endtask

  // Drive one cycle of stimulus, record what the DUT must show during it, then
  // advance the model across the following clock edge.
  task automatic step(input bit v, input int d, input bit r);
    exp_t e;
    bit   pop, push;
    in_valid  = v;
    in_data   = WIDTH'(d);
    in_par    = (^in_data) ^ par_flip;
    out_ready = r;
    e.cnt = mq.size(); e.ovf = ovf_m; e.cred = cred_m;
    e.vld = mq.size() > 0; e.hold = last_m; e.par = par_m;
    cyc_q.push_back(e);
    pop  = r && mq.size() > 0;
    push = v && (mq.size() < DEPTH || pop);
    if (pop) last_m = mq.pop_front();
    if (push) begin
      mq.push_back(d);
      exp_q.push_back(d);
      if (par_flip) par_m = 1'b1;
    end else if (v) begin
      ovf_m = 1'b1;
    end
    if (init_left > 0) begin
      cred_m = 1'b1;
      init_left--;
    end else begin
      cred_m = pop;
    end
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst_n && cyc_q.size() > 0) begin
      exp_t e;
      e = cyc_q.pop_front();
      chk("count", int'(count), e.cnt);
      chk("overflow", int'(overflow), int'(e.ovf));
      chk("credit_ret", int'(credit_ret), int'(e.cred));
      chk("out_valid", int'(out_valid), int'(e.vld));
`ifdef PIPE_CREDIT_RX_PARITY_EN
      chk("par_err", int'(par_err), int'(e.par));
`endif
      if (!out_valid) begin
        chk("out_data_hold", int'(out_data), e.hold);
      end else if (exp_q.size() == 0) begin
        chk("scoreboard_empty", int'(out_valid), 0);
      end else begin
        chk("out_data", int'(out_data), exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_credit_ret"}, int'(credit_ret), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_par_err"}, int'(par_err), 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    repeat (6) step(0, 0, 0);                       // initial credit burst
    step(1, 'h11, 0); step(1, 'h22, 0); step(1, 'h33, 0);
    repeat (4) step(0, 0, 1);                       // drain in order
    for (int i = 0; i < 4; i++) step(1, 'hC0 + i, 0);
    step(1, 'h5A, 1);                               // full, push+pop together
    repeat (5) step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 'hA0 + i, 0);
    step(1, 'hFF, 0);                               // dropped
    step(0, 0, 0);
    repeat (5) step(0, 0, 1);
    for (int i = 1; i <= 6; i++) step(1, i, 1);     // streaming, pointers wrap
    repeat (3) step(0, 0, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 255), $urandom_range(0, 99) < 70);
    repeat (6) step(0, 0, 1);

    // Asynchronous reset in the middle of traffic.
    step(1, 'h61, 0); step(1, 'h62, 0); step(1, 'h63, 0);
    chk("pre_reset_count", int'(count), 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    release_reset();
    repeat (6) step(0, 0, 0);
`ifdef PIPE_CREDIT_RX_PARITY_EN
    par_flip = 1'b1;
    step(1, 'h03, 0);
    par_flip = 1'b0;
`endif
    step(1, 'h44, 0);
    repeat (4) step(0, 0, 1);
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 99) < 50, $urandom_range(0, 255), $urandom_range(0, 99) < 60);
    repeat (8) step(0, 0, 1);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
